// File: rtl/sae_pkg.sv
// Shared types and defaults for the streaming Vigenere-style cipher.
// Characters live in a printable window [CHAR_MIN, CHAR_MAX] of RANGE symbols.
package sae_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE = 2'b00,
    MODE_ENC  = 2'b01,
    MODE_DEC  = 2'b10,
    MODE_RSV  = 2'b11
  } mode_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  localparam int unsigned CHAR_MIN_DEF = 32'h20;
  localparam int unsigned CHAR_MAX_DEF = 32'h7E;
  localparam int unsigned RANGE_DEF    = CHAR_MAX_DEF - CHAR_MIN_DEF + 1;

  // Reduces a raw key byte into the symbol range (divisor is a constant).
  function automatic logic [15:0] mod_range(input logic [15:0] value, input logic [15:0] range);
    return value % range;
  endfunction

endpackage

// File: rtl/sae_fifo.sv
// Small synchronous FIFO with first-word-fall-through read, full/empty and count.
// Pushes on a full FIFO are dropped even when a pop happens in the same cycle.
module sae_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             push, pop;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= wr_data;
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/sae_stream_cipher.sv
// Streaming cyclic-key cipher over printable characters, one char per beat,
// with per-character error flag and a small output FIFO.
module sae_stream_cipher
  import sae_pkg::*;
#(
  parameter int          DATA_W     = 8,
  parameter int          KEY_LEN    = 4,
  parameter int          FIFO_DEPTH = 4,
  parameter int unsigned CHAR_MIN   = CHAR_MIN_DEF,
  parameter int unsigned CHAR_MAX   = CHAR_MAX_DEF,
  localparam int         KW         = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic              key_we,
  input  logic [KW-1:0]     key_idx,
  input  logic [DATA_W-1:0] key_byte,
  output logic              key_busy,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_err,
  output logic              m_last
);

  localparam int unsigned RANGE   = CHAR_MAX - CHAR_MIN + 1;
  localparam int          AW      = DATA_W + 1;
  localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [AW-1:0]     RANGE_W = AW'(RANGE);
  localparam logic [AW-1:0]     CMIN_W  = AW'(CHAR_MIN);
  localparam logic [DATA_W-1:0] CMIN_D  = DATA_W'(CHAR_MIN);
  localparam logic [DATA_W-1:0] CMAX_D  = DATA_W'(CHAR_MAX);

  state_t              state_reg, state_next;
  mode_t               mode_reg, eff_mode;
  logic [KW-1:0]       ptr_reg;
  logic [DATA_W-1:0]   key_reg [KEY_LEN];
  logic [KEY_LEN-1:0]  key_slot_we;
  logic                rdy_en_reg;
  logic                accept, key_wr;
  logic                fifo_full, fifo_empty;
  logic [CW-1:0]       fifo_count;
  logic [DATA_W+1:0]   fifo_rd_data;
  logic [AW-1:0]       x, k, y;
  logic                in_range, err;
  logic [DATA_W-1:0]   res_data;

  assign s_ready  = rdy_en_reg && !fifo_full;
  assign accept   = s_valid && s_ready;
  assign key_busy = (state_reg == ST_ACTIVE);
  assign key_wr   = key_we && !key_busy && !accept;
  // The first beat of a message uses the live mode; later beats the latched copy.
  assign eff_mode = (state_reg == ST_IDLE) ? mode_t'(mode) : mode_reg;

  for (genvar gi = 0; gi < KEY_LEN; gi++) begin : g_key_we
    assign key_slot_we[gi] = key_wr && (key_idx == KW'(gi));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < KEY_LEN; i++) key_reg[i] <= '0;
    end else begin
      for (int i = 0; i < KEY_LEN; i++)
        if (key_slot_we[i]) key_reg[i] <= key_byte;
    end
  end

  always_comb begin
    x        = {1'b0, s_data} - CMIN_W;
    k        = AW'(mod_range(16'(key_reg[ptr_reg]), 16'(RANGE)));
    in_range = (s_data >= CMIN_D) && (s_data <= CMAX_D);
    err      = !in_range || !((eff_mode == MODE_ENC) || (eff_mode == MODE_DEC));
    if (eff_mode == MODE_ENC) begin
      y = x + k;
      if (y >= RANGE_W) y = y - RANGE_W;
    end else begin
      y = (x >= k) ? (x - k) : (x + RANGE_W - k);
    end
    res_data = err ? '0 : DATA_W'(y + CMIN_W);
  end

  always_comb begin
    state_next = state_reg;
    if (accept) state_next = s_last ? ST_IDLE : ST_ACTIVE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      mode_reg   <= MODE_IDLE;
      ptr_reg    <= '0;
      rdy_en_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      rdy_en_reg <= 1'b1;
      if (accept) begin
        if (state_reg == ST_IDLE) mode_reg <= mode_t'(mode);
        if (s_last || (ptr_reg == KW'(KEY_LEN - 1))) ptr_reg <= '0;
        else                                         ptr_reg <= ptr_reg + 1'b1;
      end
    end
  end

  sae_fifo #(
    .WIDTH (DATA_W + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (accept),
    .wr_data ({s_last, err, res_data}),
    .rd_en   (m_ready),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign m_valid                  = (fifo_count != '0);
  assign {m_last, m_err, m_data}  = fifo_empty ? '0 : fifo_rd_data;

endmodule
